// File: rtl/sp_reset_seq.sv
// rtl/sp_reset_seq.sv - staged flop-bank reset sequencer with soft-reset handshake
//
// Purpose:
//   Holds every flop bank in reset (active-low clear) while reset is high,
//   then releases the banks one at a time, STAGE_GAP clocks apart, after the
//   reset deassertion has been synchronized to clk. In normal operation a
//   software soft-reset request re-runs the staged release and completes
//   with a 4-phase req/ack handshake.
//
// Ports:
//   clk            in   1           core clock
//   reset          in   1           asynchronous, active-high system reset
//   soft_req       in   1           soft-reset request (level, 4-phase)
//   hold           in   1           1 = freeze the release counter
//   soft_ack       out  1           soft-reset complete (level, 4-phase)
//   stage_reset_l  out  NUM_STAGES  active-low bank clears, bit k -> bank k
//   all_released   out  1           1 = every bank out of reset
//   seq_busy       out  1           1 = sequence in progress or held in reset

module sp_reset_seq #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_GAP  = 8,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_req,
    input  logic                  hold,
    output logic                  soft_ack,
    output logic [NUM_STAGES-1:0] stage_reset_l,
    output logic                  all_released,
    output logic                  seq_busy
);

    localparam int CNT_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IDX_W = ($clog2(NUM_STAGES + 1) > 1) ? $clog2(NUM_STAGES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_RELEASE,
        S_RUN,
        S_SOFT_ASSERT,
        S_ACK
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic                    soft_pend;
    logic                    soft_pend_next;
    logic [NUM_STAGES-1:0]   stage_next;
    logic                    all_next;
    logic                    busy_next;
    logic                    ack_next;

    // Deassertion synchronizer: set to all-ones by reset, then drains zeros
    // from the input end so the sequencer only leaves SYNC on a clean edge.
    logic [SYNC_DEPTH-1:0]   sync;
    logic                    sync_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    assign sync_out = sync[SYNC_DEPTH-1];

    // All state and every output are registered here; the combinational
    // block below only computes their next values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_SYNC;
            cnt           <= '0;
            idx           <= '0;
            soft_pend     <= 1'b0;
            stage_reset_l <= '0;
            all_released  <= 1'b0;
            seq_busy      <= 1'b1;
            soft_ack      <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            idx           <= idx_next;
            soft_pend     <= soft_pend_next;
            stage_reset_l <= stage_next;
            all_released  <= all_next;
            seq_busy      <= busy_next;
            soft_ack      <= ack_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        idx_next       = idx;
        soft_pend_next = soft_pend;
        stage_next     = stage_reset_l;
        all_next       = all_released;
        busy_next      = seq_busy;
        ack_next       = soft_ack;

        case (state)
            S_SYNC: begin
                if (!sync_out) begin
                    state_next = S_RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end

            S_RELEASE: begin
                // hold freezes both the gap counter and the bank index, so
                // every later release slips by exactly the stalled cycles.
                if (!hold) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next = '0;
                        idx_next = idx + IDX_W'(1);
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (idx == IDX_W'(k)) begin
                                stage_next[k] = 1'b1;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            all_next  = 1'b1;
                            busy_next = 1'b0;
                            if (soft_pend) begin
                                // Ack rises together with all_released.
                                ack_next   = 1'b1;
                                state_next = S_ACK;
                            end else begin
                                state_next = S_RUN;
                            end
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end

            S_RUN: begin
                // Only RUN samples soft_req; requests seen elsewhere are dropped.
                if (soft_req) begin
                    stage_next     = '0;
                    all_next       = 1'b0;
                    busy_next      = 1'b1;
                    soft_pend_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = S_SOFT_ASSERT;
                end
            end

            S_SOFT_ASSERT: begin
                // Banks stay cleared for STAGE_GAP edges regardless of hold.
                if (cnt == CNT_LAST) begin
                    state_next = S_RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            S_ACK: begin
                // Leaving only on soft_req=0 prevents a held request from
                // retriggering a second soft reset.
                if (!soft_req) begin
                    ack_next       = 1'b0;
                    soft_pend_next = 1'b0;
                    state_next     = S_RUN;
                end
            end

            default: begin
                state_next = S_SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_sp_reset_seq.sv
// tb/tb_sp_reset_seq.sv - self-checking bench for sp_reset_seq (default and corner parameters)

module tb_sp_reset_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: default parameters. Instance b: NUM_STAGES=1, STAGE_GAP=1.
    logic       reset_a, soft_req_a, hold_a, soft_ack_a, all_a, busy_a;
    logic [3:0] stage_a;
    logic       reset_b, soft_req_b, hold_b, soft_ack_b, all_b, busy_b;
    logic [0:0] stage_b;

    sp_reset_seq #(.NUM_STAGES(4), .STAGE_GAP(8), .SYNC_DEPTH(2)) dut_a (
        .clk           (clk),
        .reset         (reset_a),
        .soft_req      (soft_req_a),
        .hold          (hold_a),
        .soft_ack      (soft_ack_a),
        .stage_reset_l (stage_a),
        .all_released  (all_a),
        .seq_busy      (busy_a)
    );

    sp_reset_seq #(.NUM_STAGES(1), .STAGE_GAP(1), .SYNC_DEPTH(2)) dut_b (
        .clk           (clk),
        .reset         (reset_b),
        .soft_req      (soft_req_b),
        .hold          (hold_b),
        .soft_ack      (soft_ack_b),
        .stage_reset_l (stage_b),
        .all_released  (all_b),
        .seq_busy      (busy_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: tracks how many banks are released and the absolute
    // edge number of the next release; hold pushes that edge out by one.
    int p_num [2] = '{4, 1};
    int p_gap [2] = '{8, 1};
    int p_sd  [2] = '{2, 2};

    int m_n    [2];   // edge number since reset release (-1 while in reset)
    int m_rel  [2];   // banks released
    int m_ws   [2];   // last edge before hold becomes effective
    int m_next [2];   // edge on which the next bank is released
    int m_mode [2];   // 0 sequencing, 1 running, 2 acknowledging
    bit m_pend [2];

    task automatic model_reset(input int i);
        m_n[i]    = -1;
        m_rel[i]  = 0;
        m_mode[i] = 0;
        m_pend[i] = 1'b0;
        m_ws[i]   = p_sd[i];
        m_next[i] = p_sd[i] + p_gap[i];
    endtask

    task automatic model_edge(input int i, input bit req, input bit hld);
        m_n[i]++;
        case (m_mode[i])
            0: begin
                if (m_n[i] > m_ws[i]) begin
                    if (hld) begin
                        m_next[i]++;
                    end else if (m_n[i] == m_next[i]) begin
                        m_rel[i]++;
                        m_next[i] += p_gap[i];
                        if (m_rel[i] == p_num[i]) m_mode[i] = m_pend[i] ? 2 : 1;
                    end
                end
            end
            1: begin
                if (req) begin
                    m_rel[i]  = 0;
                    m_pend[i] = 1'b1;
                    m_ws[i]   = m_n[i] + p_gap[i];
                    m_next[i] = m_n[i] + 2 * p_gap[i];
                    m_mode[i] = 0;
                end
            end
            default: begin
                if (!req) begin
                    m_mode[i] = 1;
                    m_pend[i] = 1'b0;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] exp_stage(input int i);
        return (32'd1 << m_rel[i]) - 32'd1;
    endfunction

    task automatic check_a(input string tag);
        check({tag, "_a_stage"}, 32'(stage_a), exp_stage(0));
        check({tag, "_a_all"},   32'(all_a),   32'(m_rel[0] == p_num[0]));
        check({tag, "_a_busy"},  32'(busy_a),  32'(m_rel[0] != p_num[0]));
        check({tag, "_a_ack"},   32'(soft_ack_a), 32'(m_mode[0] == 2));
    endtask

    task automatic check_b(input string tag);
        check({tag, "_b_stage"}, 32'(stage_b), exp_stage(1));
        check({tag, "_b_all"},   32'(all_b),   32'(m_rel[1] == p_num[1]));
        check({tag, "_b_busy"},  32'(busy_b),  32'(m_rel[1] != p_num[1]));
        check({tag, "_b_ack"},   32'(soft_ack_b), 32'(m_mode[1] == 2));
    endtask

    // One clock: update the model on the rising edge, compare on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (!reset_a) model_edge(0, soft_req_a, hold_a);
        if (!reset_b) model_edge(1, soft_req_b, hold_b);
        @(negedge clk);
        check_a(tag);
        check_b(tag);
    endtask

    // Called just after a falling edge: assert reset mid-cycle, confirm the
    // outputs clear before any clock edge, hold two cycles, release.
    task automatic do_reset(input string tag);
        #2;
        reset_a = 1'b1;
        reset_b = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_a(tag);
        check_b(tag);
        step(tag);
        step(tag);
        reset_a = 1'b0;
        reset_b = 1'b0;
    endtask

    initial begin
        int e_a;
        int e_b;

        reset_a = 1'b1; soft_req_a = 1'b0; hold_a = 1'b0;
        reset_b = 1'b1; soft_req_b = 1'b0; hold_b = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        check("rst_a_stage", 32'(stage_a), 32'h0);
        check("rst_a_busy",  32'(busy_a),  32'h1);
        check("rst_b_stage", 32'(stage_b), 32'h0);
        check("rst_b_busy",  32'(busy_b),  32'h1);
        step("rst");
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Power-up release, with an ignored soft_req pulse sampled at edge 20.
        for (int c = 0; c < 40; c++) begin
            soft_req_a = (m_n[0] + 1 == 20);
            step("pwr");
            if (m_n[0] == 9)  check("pwr_e9",  32'(stage_a), 32'h0);
            if (m_n[0] == 10) check("pwr_e10", 32'(stage_a), 32'h1);
            if (m_n[0] == 18) check("pwr_e18", 32'(stage_a), 32'h3);
            if (m_n[0] == 26) check("pwr_e26", 32'(stage_a), 32'h7);
            if (m_n[0] == 33) check("pwr_e33_all", 32'(all_a), 32'h0);
            if (m_n[0] == 34) check("pwr_e34", 32'(stage_a), 32'hf);
            if (m_n[0] == 34) check("pwr_e34_busy", 32'(busy_a), 32'h0);
            if (m_n[0] == 38) check("pwr_ack", 32'(soft_ack_a), 32'h0);
            if (m_n[1] == 2)  check("cor_e2", 32'(stage_b), 32'h0);
            if (m_n[1] == 3)  check("cor_e3", 32'(stage_b), 32'h1);
        end

        // Hold for edges 12..16.
        do_reset("hrst");
        for (int c = 0; c < 50; c++) begin
            hold_a = (m_n[0] + 1 >= 12) && (m_n[0] + 1 <= 16);
            step("hold");
            if (m_n[0] == 10) check("hold_e10", 32'(stage_a), 32'h1);
            if (m_n[0] == 22) check("hold_e22", 32'(stage_a), 32'h1);
            if (m_n[0] == 23) check("hold_e23", 32'(stage_a), 32'h3);
            if (m_n[0] == 38) check("hold_e38", 32'(stage_a), 32'h7);
            if (m_n[0] == 39) check("hold_e39", 32'(stage_a), 32'hf);
        end
        hold_a = 1'b0;

        // Soft reset on both instances; request held well past the ack.
        soft_req_a = 1'b1;
        soft_req_b = 1'b1;
        e_a = m_n[0] + 1;
        e_b = m_n[1] + 1;
        for (int c = 0; c < 50; c++) begin
            step("soft");
            if (m_n[0] == e_a)      check("soft_clr",  32'(stage_a), 32'h0);
            if (m_n[0] == e_a + 15) check("soft_e15",  32'(stage_a), 32'h0);
            if (m_n[0] == e_a + 16) check("soft_e16",  32'(stage_a), 32'h1);
            if (m_n[0] == e_a + 39) check("soft_e39_ack", 32'(soft_ack_a), 32'h0);
            if (m_n[0] == e_a + 40) check("soft_e40_ack", 32'(soft_ack_a), 32'h1);
            if (m_n[0] == e_a + 40) check("soft_e40", 32'(stage_a), 32'hf);
            if (m_n[1] == e_b + 1)  check("cor_soft_clr", 32'(stage_b), 32'h0);
            if (m_n[1] == e_b + 2)  check("cor_soft_ack", 32'(soft_ack_b), 32'h1);
        end
        check("soft_held_ack", 32'(soft_ack_a), 32'h1);
        soft_req_a = 1'b0;
        soft_req_b = 1'b0;
        step("drop");
        check("drop_ack_a", 32'(soft_ack_a), 32'h0);
        check("drop_ack_b", 32'(soft_ack_b), 32'h0);
        step("drop");

        // Reset mid-sequence after edge 22.
        do_reset("mrst");
        while (m_n[0] < 22) step("mid");
        #2;
        reset_a = 1'b1;
        #1;
        check("mid_stage", 32'(stage_a), 32'h0);
        check("mid_busy",  32'(busy_a),  32'h1);
        check("mid_all",   32'(all_a),   32'h0);
        model_reset(0);
        step("mid");
        reset_a = 1'b0;
        for (int c = 0; c < 36; c++) begin
            step("rerun");
            if (m_n[0] == 10) check("rerun_e10", 32'(stage_a), 32'h1);
            if (m_n[0] == 34) check("rerun_e34", 32'(stage_a), 32'hf);
        end

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) soft_req_a = ~soft_req_a;
            if ($urandom_range(0, 9) == 0)  soft_req_b = ~soft_req_b;
            hold_a = ($urandom_range(0, 3) == 0);
            hold_b = ($urandom_range(0, 3) == 0);
            if (reset_a) begin
                reset_a = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                #2;
                reset_a = 1'b1;
                model_reset(0);
                #1;
                check_a("rnd_rst");
            end
            if (reset_b) begin
                reset_b = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                #1;
                reset_b = 1'b1;
                model_reset(1);
                #1;
                check_b("rnd_rst");
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
